fetch_stack_unit: RTL and testbench

//  Parametrised PC / IR / SP front end for the multicycle CPU datapath; successor to the fixed 16-bit PC-Mem-IR-SP integration.

---
 rtl/fetch_stack_unit_if.sv | 31 +++
 rtl/fetch_stack_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_stack_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stack_unit_if.sv
// Single-port memory bus between the fetch/stack front end (master) and memory (slave).
// The master holds req/addr/we/wdata stable until the slave signals rdy.
interface fetch_stack_unit_if #(
  parameter int unsigned DataW = 16,
  parameter int unsigned AddrW = 16
) ();
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata;
  logic             mem_we;
  logic             mem_req;
  logic             mem_rdy;
  logic [DataW-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_req,
    input  mem_rdy,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_req,
    output mem_rdy,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_stack_unit.sv
// PC / IR / down-growing SP front end sharing one ready-handshaked memory port between
// instruction fetch, data access and push/pop, with sticky stack overflow/underflow flag.
module fetch_stack_unit #(
  parameter int unsigned      DataW   = 16,
  parameter int unsigned      AddrW   = 16,
  parameter logic [AddrW-1:0] ResetPc = '0,
  parameter logic [AddrW-1:0] SpTop   = '1,
  parameter logic [AddrW-1:0] SpLimit = 16'hFF00
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 fetch_i,
  input  logic                 pcw_i,
  input  logic                 jump_i,
  input  logic [AddrW-1:0]     jump_addr_i,
  input  logic [1:0]           sp_op_i,
  input  logic                 write_i,
  input  logic                 dreq_i,
  input  logic [AddrW-1:0]     ma_i,
  input  logic [DataW-1:0]     mwd_i,
  input  logic                 err_clr_i,
  fetch_stack_unit_if.master   mem,
  output logic [DataW-1:0]     ir_o,
  output logic [3:0]           op_o,
  output logic [DataW-1:0]     rdata_o,
  output logic [AddrW-1:0]     pc_o,
  output logic [AddrW-1:0]     sp_o,
  output logic                 busy_o,
  output logic                 stack_err_o
);

  typedef enum logic [1:0] {StIdle, StIfetch, StDacc} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] pc_q, pc_d, sp_q, sp_d, addr_q, addr_d;
  logic [DataW-1:0] ir_q, ir_d, rdata_q, rdata_d, wdata_q, wdata_d;
  logic             req_q, req_d, we_q, we_d, pop_q, pop_d, err_q, err_d, err_set;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    ir_d    = ir_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    pop_d   = pop_q;
    err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Fixed priority; anything below the accepted request is dropped.
        if (fetch_i) begin
          state_d = StIfetch;
          req_d   = 1'b1;
          addr_d  = pc_q;
          we_d    = 1'b0;
        end else if (sp_op_i == 2'b01) begin
          if (sp_q == SpLimit) begin
            err_set = 1'b1;
          end else begin
            sp_d    = sp_q - AddrW'(1);
            state_d = StDacc;
            req_d   = 1'b1;
            addr_d  = sp_q - AddrW'(1);
            we_d    = 1'b1;
            wdata_d = mwd_i;
            pop_d   = 1'b0;
          end
        end else if (sp_op_i == 2'b10) begin
          if (sp_q == SpTop) begin
            err_set = 1'b1;
          end else begin
            state_d = StDacc;
            req_d   = 1'b1;
            addr_d  = sp_q;
            we_d    = 1'b0;
            pop_d   = 1'b1;
          end
        end else if (dreq_i) begin
          state_d = StDacc;
          req_d   = 1'b1;
          addr_d  = ma_i;
          we_d    = write_i;
          wdata_d = mwd_i;
          pop_d   = 1'b0;
        end else if (pcw_i) begin
          pc_d = jump_i ? jump_addr_i : pc_q + AddrW'(1);
        end
      end
      StIfetch: begin
        if (mem.mem_rdy) begin
          ir_d    = mem.mem_rdata;
          pc_d    = pc_q + AddrW'(1);
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      StDacc: begin
        if (mem.mem_rdy) begin
          if (!we_q) rdata_d = mem.mem_rdata;
          if (pop_q) sp_d = sp_q + AddrW'(1);
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A fresh error outranks a simultaneous clear.
    err_d = err_set | (err_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pc_q    <= ResetPc;
      sp_q    <= SpTop;
      ir_q    <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      pop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ir_q    <= ir_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      pop_q   <= pop_d;
      err_q   <= err_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_wdata = wdata_q;
  assign ir_o          = ir_q;
  assign op_o          = ir_q[DataW-1 -: 4];
  assign rdata_o       = rdata_q;
  assign pc_o          = pc_q;
  assign sp_o          = sp_q;
  assign busy_o        = (state_q != StIdle);
  assign stack_err_o   = err_q;

endmodule

// File: tb/tb_fetch_stack_unit.sv
// Directed bench: transaction-level reference model checked every cycle, plus literal pins.
module tb_fetch_stack_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch = 0, pcw = 0, jump = 0, write = 0, dreq = 0, err_clr = 0, rdy = 1;
  logic [1:0]  sp_op = 2'b00;
  logic [15:0] jump_addr = '0, ma = '0, mwd = '0;
  logic [15:0] ir, rdata, pc, sp;
  logic [3:0]  op;
  logic        busy, stack_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stack_unit_if #(.DataW(16), .AddrW(16)) bus ();

  fetch_stack_unit dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .fetch_i     (fetch),
    .pcw_i       (pcw),
    .jump_i      (jump),
    .jump_addr_i (jump_addr),
    .sp_op_i     (sp_op),
    .write_i     (write),
    .dreq_i      (dreq),
    .ma_i        (ma),
    .mwd_i       (mwd),
    .err_clr_i   (err_clr),
    .mem         (bus),
    .ir_o        (ir),
    .op_o        (op),
    .rdata_o     (rdata),
    .pc_o        (pc),
    .sp_o        (sp),
    .busy_o      (busy),
    .stack_err_o (stack_err)
  );

  // Slave memory
  logic [15:0] mem [0:65535];
  assign bus.mem_rdy   = rdy;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_we && bus.mem_rdy) mem[bus.mem_addr] = bus.mem_wdata;
  end

  // Reference model: architectural registers plus one outstanding memory transaction.
  typedef enum {KFetch, KRead, KWrite, KPop, KPush} kind_e;
  logic [15:0] ref_mem [0:65535];
  logic [15:0] m_pc, m_sp, m_ir, m_rdata, m_addr, m_wdata;
  logic        m_err, m_busy, m_req, m_we, m_err_new;
  kind_e       m_kind;

  task automatic set_mem(input logic [15:0] a, input logic [15:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 16'h0000; m_sp = 16'hFFFF; m_ir = '0; m_rdata = '0; m_err = 1'b0;
      m_busy = 1'b0; m_req = 1'b0; m_addr = '0; m_we = 1'b0; m_wdata = '0; m_kind = KFetch;
    end else begin
      m_err_new = 1'b0;
      if (m_busy) begin
        if (rdy) begin
          case (m_kind)
            KFetch:  begin m_ir = ref_mem[m_addr]; m_pc = m_pc + 16'd1; end
            KRead:   m_rdata = ref_mem[m_addr];
            KPop:    begin m_rdata = ref_mem[m_addr]; m_sp = m_sp + 16'd1; end
            default: ref_mem[m_addr] = m_wdata;
          endcase
          m_busy = 1'b0;
          m_req  = 1'b0;
        end
      end else if (fetch) begin
        m_kind = KFetch; m_busy = 1'b1; m_req = 1'b1; m_addr = m_pc; m_we = 1'b0;
      end else if (sp_op == 2'b01) begin
        if (m_sp == 16'hFF00) m_err_new = 1'b1;
        else begin
          m_sp = m_sp - 16'd1;
          m_kind = KPush; m_busy = 1'b1; m_req = 1'b1; m_addr = m_sp; m_we = 1'b1; m_wdata = mwd;
        end
      end else if (sp_op == 2'b10) begin
        if (m_sp == 16'hFFFF) m_err_new = 1'b1;
        else begin
          m_kind = KPop; m_busy = 1'b1; m_req = 1'b1; m_addr = m_sp; m_we = 1'b0;
        end
      end else if (dreq) begin
        m_kind = write ? KWrite : KRead;
        m_busy = 1'b1; m_req = 1'b1; m_addr = ma; m_we = write; m_wdata = mwd;
      end else if (pcw) begin
        m_pc = jump ? jump_addr : m_pc + 16'd1;
      end
      m_err = m_err_new | (m_err & ~err_clr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("sp", sp, m_sp);
    chk("ir", ir, m_ir);
    chk("op", op, m_ir[15:12]);
    chk("rdata", rdata, m_rdata);
    chk("stack_err", stack_err, m_err);
    chk("busy", busy, m_busy);
    chk("mem_req", bus.mem_req, m_req);
    if (m_req) begin
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_we", bus.mem_we, m_we);
      if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    set_mem(16'h0000, 16'h3ABC);
    set_mem(16'h0041, 16'h5A5A);
    set_mem(16'h0042, 16'h7123);
    set_mem(16'h0300, 16'h9999);
    #1 rst_n = 1'b0;
    cyc(2);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_sp", sp, 16'hFFFF);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // First fetch
    fetch = 1'b1;
    cyc(1);
    fetch = 1'b0;
    chk("f_req", bus.mem_req, 1'b1);
    chk("f_addr", bus.mem_addr, 16'h0000);
    cyc(1);
    chk("f_ir", ir, 16'h3ABC);
    chk("f_op", op, 4'h3);
    chk("f_pc", pc, 16'h0001);

    // PC write: jump then increment
    pcw = 1'b1; jump = 1'b1; jump_addr = 16'h0040;
    cyc(1);
    chk("jump_pc", pc, 16'h0040);
    jump = 1'b0;
    cyc(1);
    chk("inc_pc", pc, 16'h0041);
    pcw = 1'b0;

    // Fetch stalled 3 cycles
    fetch = 1'b1; rdy = 1'b0;
    cyc(1);
    fetch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_req", bus.mem_req, 1'b1);
      chk("stall_addr", bus.mem_addr, 16'h0041);
      chk("stall_ir", ir, 16'h3ABC);
      if (i == 3) rdy = 1'b1;
      cyc(1);
    end
    chk("stall_ir_done", ir, 16'h5A5A);
    chk("stall_pc", pc, 16'h0042);

    // Push then pop
    sp_op = 2'b01; mwd = 16'h1234;
    cyc(1);
    sp_op = 2'b00;
    chk("push_sp", sp, 16'hFFFE);
    chk("push_addr", bus.mem_addr, 16'hFFFE);
    chk("push_we", bus.mem_we, 1'b1);
    cyc(1);
    sp_op = 2'b10;
    cyc(1);
    sp_op = 2'b00;
    chk("pop_addr", bus.mem_addr, 16'hFFFE);
    cyc(1);
    chk("pop_rdata", rdata, 16'h1234);
    chk("pop_sp", sp, 16'hFFFF);

    // Underflow
    sp_op = 2'b10;
    cyc(1);
    sp_op = 2'b00;
    chk("uf_err", stack_err, 1'b1);
    chk("uf_req", bus.mem_req, 1'b0);
    chk("uf_sp", sp, 16'hFFFF);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("clr_err", stack_err, 1'b0);

    // Fill the stack to its limit, then overflow
    for (int i = 0; i < 255; i++) begin
      sp_op = 2'b01; mwd = 16'h0100 + 16'(i);
      cyc(1);
      sp_op = 2'b00;
      cyc(1);
    end
    chk("full_sp", sp, 16'hFF00);
    sp_op = 2'b01;
    cyc(1);
    chk("of_err", stack_err, 1'b1);
    chk("of_sp", sp, 16'hFF00);
    err_clr = 1'b1;
    cyc(1);
    chk("of_err_wins", stack_err, 1'b1);
    sp_op = 2'b00;
    cyc(1);
    err_clr = 1'b0;
    chk("of_cleared", stack_err, 1'b0);
    sp_op = 2'b10;
    cyc(1);
    sp_op = 2'b00;
    cyc(1);
    chk("pop_last", rdata, 16'h01FE);
    chk("pop_last_sp", sp, 16'hFF01);

    // Data write then read
    dreq = 1'b1; write = 1'b1; ma = 16'h0100; mwd = 16'hBEEF;
    cyc(1);
    dreq = 1'b0;
    cyc(1);
    dreq = 1'b1; write = 1'b0;
    cyc(1);
    dreq = 1'b0;
    cyc(1);
    chk("dread", rdata, 16'hBEEF);

    // Fetch beats DReq in the same cycle
    fetch = 1'b1; dreq = 1'b1; write = 1'b1; ma = 16'h0200; mwd = 16'hDEAD;
    cyc(1);
    fetch = 1'b0; dreq = 1'b0;
    chk("prio_addr", bus.mem_addr, 16'h0042);
    chk("prio_we", bus.mem_we, 1'b0);
    cyc(1);
    chk("prio_ir", ir, 16'h7123);
    chk("prio_busy", busy, 1'b0);

    // Reset during a stalled data access
    dreq = 1'b1; write = 1'b0; ma = 16'h0300; rdy = 1'b0;
    cyc(1);
    dreq = 1'b0;
    cyc(1);
    chk("pre_rst_req", bus.mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", bus.mem_req, 1'b0);
    chk("ar_pc", pc, 16'h0000);
    chk("ar_sp", sp, 16'hFFFF);
    chk("ar_busy", busy, 1'b0);
    cyc(1);
    rst_n = 1'b1; rdy = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
